vect_lane_serializer: RTL and testbench
=======================================

# vect_lane_serializer

- Drains one packed vector (vecSize lanes of regSize bits) into a stream of scalar lane elements, lowest lane first, skipping disabled lanes.
- Sits on the SIMD store path after the final vector pipeline stage; feeds the scalar-width data-memory write port.
- Valid/ready on both sides, with zero-bubble back-to-back vectors.

## Interface
Parameters:
- WIDTH, 8, width of the control/tag word travelling with the vector
- regSize, 16, bits per lane element
- vecSize, 4, lanes per vector (≥2)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- in_valid  in  1  upstream vector valid
- in_ready  out  1  serializer can accept a vector this cycle
- in_tag  in  WIDTH  control/tag word (store base address/opcode)
- in_vect  in  [vecSize-1:0][regSize-1:0]  vector payload
- in_mask  in  vecSize  lane enable, bit i = emit lane i
- out_valid  out  1  element valid
- out_ready  in  1  downstream accepts element
- out_data  out  regSize  current lane element
- out_lane  out  $clog2(vecSize)  index of current lane
- out_tag  out  WIDTH  tag of the vector being drained
- out_last  out  1  current element is the vector's last enabled lane
- busy  out  1  a vector is held (state SEND)

## Operation
- Registers: vect_q, tag_q, pend_q (remaining-lane mask, vecSize bits), state.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid=1 with in_mask≠0: capture vect/tag/mask, go SEND.
  - in_valid=1 with in_mask=0: accept and discard; stay IDLE; no output.
- SEND:
  - out_valid=1.
  - out_lane = lowest set bit of pend_q; out_data = vect_q[out_lane]; out_tag = tag_q.
  - out_last = (popcount(pend_q)==1).
  - Element transfer (out_valid & out_ready): clear bit out_lane in pend_q.
  - Transfer of the last element: go IDLE, unless a new vector is accepted the same cycle.
- Back-to-back: in SEND, in_ready = out_last & out_ready (combinational from out_ready).
  - If in_valid in that cycle with nonzero mask: load the new vector and stay SEND.
  - If in_valid with zero mask: discard the new vector and go IDLE.
- Output stability: out_data/out_lane/out_tag/out_last stay stable while out_valid & !out_ready.
- Upstream rule: in_* are sampled only on the handshake cycle. Changes while in_ready=0 are ignored.
- Reset (rst=0, async):
  - state=IDLE; vect_q, tag_q, pend_q = 0.
  - out_valid=0, out_last=0, out_data=0, out_lane=0, out_tag=0, busy=0.
  - in_ready forced 0 while rst=0.
- Reset mid-vector: remaining lanes are dropped, with no partial completion.

## Timing
- Latency: vector accepted at edge N, first element valid after edge N (cycle N+1). Output is registered state, so no in→out combinational path.
- Throughput: popcount(in_mask) cycles per vector with out_ready held 1, and no idle cycle between vectors.
- out_ready=0 stalls without limit, with no loss.
- Only in_ready depends combinationally on out_ready.
- in_ready is 1 in the first cycle after rst deasserts.

## Structure
- Shared package simd_pkg holds:
  - lane index type: logic [$clog2(vecSize)-1:0]
  - state enum {IDLE, SEND}
  - vector type alias: [vecSize-1:0][regSize-1:0]
- Sub-module lane_prio_enc, parameterized by vecSize.
  - Inputs: mask. Outputs: lowest set index, any, exactly_one.
  - Used to derive out_lane and out_last.

## Test plan
- Reset then full mask: in_vect={0x4444,0x3333,0x2222,0x1111}, mask=4'b1111, out_ready=1 → out_data 0x1111,0x2222,0x3333,0x4444 on cycles N+1..N+4, out_lane 0..3, out_last only on 0x4444, tag echoed.
- Sparse mask 4'b1010 → two elements, lane1 then lane3 (out_last=1); busy drops after the second transfer.
- Zero mask: in_mask=0 accepted in IDLE → no out_valid ever, in_ready stays 1.
- Backpressure: out_ready toggles 1,0,0,1 (random thereafter) → each element held stable during stalls, none lost or duplicated, order preserved.
- Back-to-back: second vector (tag 0x5A) valid during the first's last element → in_ready=1 that cycle, next cycle emits the second vector's lane0, no bubble.
- Mid-vector reset: rst=0 after 2 of 4 elements → out_valid, busy, all outputs 0 immediately (async); after release, in_ready=1 and a fresh vector drains correctly.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared SIMD store-path types.
//   lane_idx_t : index of one lane in a default-sized vector
//   vect_t     : default-sized packed vector (lanes x element bits)
//   state_t    : serializer FSM state
package simd_pkg;

    localparam int VEC_SIZE = 4;
    localparam int REG_SIZE = 16;

    typedef logic [$clog2(VEC_SIZE)-1:0]         lane_idx_t;
    typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0]   vect_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over a lane mask.
//   mask        in  lane bit mask
//   idx         out index of the lowest set bit (0 when mask is empty)
//   any         out mask has at least one bit set
//   exactly_one out mask has exactly one bit set
module lane_prio_enc #(
    parameter int vecSize = 4
) (
    input  logic [vecSize-1:0]         mask,
    output logic [$clog2(vecSize)-1:0] idx,
    output logic                       any,
    output logic                       exactly_one
);

    localparam int LW = $clog2(vecSize);

    // Scan high to low so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = vecSize - 1; i >= 0; i--) begin
            if (mask[i]) idx = LW'(i);
        end
    end

    assign any         = |mask;
    // Clearing the lowest set bit leaves nothing exactly when one bit was set.
    assign exactly_one = any && ((mask & (mask - vecSize'(1))) == '0);

endmodule

// File: rtl/vect_lane_serializer.sv
// Drains one packed vector into a stream of scalar lane elements, lowest
// enabled lane first, with zero-bubble back-to-back vectors.
//   clk, rst              clock; asynchronous active-low reset
//   in_valid/in_ready     upstream vector handshake
//   in_tag/vect/mask      tag word, payload, lane enables
//   out_valid/out_ready   downstream element handshake
//   out_data/lane/tag     current element, its lane index, vector tag
//   out_last              current element is the vector's last enabled lane
//   busy                  a vector is held
module vect_lane_serializer
    import simd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int regSize = REG_SIZE,
    parameter int vecSize = VEC_SIZE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_tag,
    input  logic [vecSize-1:0][regSize-1:0]   in_vect,
    input  logic [vecSize-1:0]                in_mask,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [regSize-1:0]                out_data,
    output logic [$clog2(vecSize)-1:0]        out_lane,
    output logic [WIDTH-1:0]                  out_tag,
    output logic                              out_last,
    output logic                              busy
);

    localparam int LW = $clog2(vecSize);

    state_t                            state, state_n;
    logic [vecSize-1:0][regSize-1:0]   vect_q, vect_n;
    logic [WIDTH-1:0]                  tag_q, tag_n;
    logic [vecSize-1:0]                pend_q, pend_n;
    logic [vecSize-1:0]                lane_oh;
    logic [LW-1:0]                     lane;
    logic                              any, one, send, accept;

    lane_prio_enc #(.vecSize(vecSize)) u_enc (
        .mask        (pend_q),
        .idx         (lane),
        .any         (any),
        .exactly_one (one)
    );

    assign send      = (state == SEND);
    assign busy      = send;
    assign out_valid = send & any;
    assign out_lane  = send ? lane : '0;
    assign out_data  = send ? vect_q[lane] : '0;
    assign out_tag   = send ? tag_q : '0;
    assign out_last  = send & one;

    // A new vector fits while idle, or while the final element leaves now.
    assign in_ready = rst & (!send | (one & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_n = state;
        vect_n  = vect_q;
        tag_n   = tag_q;
        pend_n  = pend_q;
        lane_oh = '0;
        lane_oh[lane] = 1'b1;
        if (send && out_ready) begin
            pend_n = pend_q & ~lane_oh;
            if (one) state_n = IDLE;
        end
        // Zero-mask vectors are consumed without output; state stays/turns IDLE.
        if (accept && (in_mask != '0)) begin
            vect_n  = in_vect;
            tag_n   = in_tag;
            pend_n  = in_mask;
            state_n = SEND;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            vect_q <= '0;
            tag_q  <= '0;
            pend_q <= '0;
        end else begin
            state  <= state_n;
            vect_q <= vect_n;
            tag_q  <= tag_n;
            pend_q <= pend_n;
        end
    end

endmodule

// File: tb/tb_vect_lane_serializer.sv
module tb_vect_lane_serializer;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        in_tag = '0;
    logic [3:0][15:0]  in_vect = '0;
    logic [3:0]        in_mask = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_data;
    logic [1:0]        out_lane;
    logic [7:0]        out_tag;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int failures = 0;

    vect_lane_serializer #(.WIDTH(8), .regSize(16), .vecSize(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_vect(in_vect), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_tag(out_tag), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_elem(input string tag, input logic [15:0] d, input logic [1:0] l,
                            input logic last, input logic [7:0] t);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_lane"},  32'(out_lane),  32'(l));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_tag"},   32'(out_tag),   32'(t));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_lane"},  32'(out_lane),  32'd0);
        chk({tag, "_tag"},   32'(out_tag),   32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    // Offer a vector at a negedge; it is accepted on the following posedge.
    task automatic offer(input logic [7:0] t, input logic [63:0] v, input logic [3:0] m);
        in_valid = 1'b1;
        in_tag   = t;
        in_vect  = v;
        in_mask  = m;
    endtask

    logic [15:0] bp_exp [4];
    int          idx;

    initial begin
        // Reset state
        #3;
        chk_zero("rst");
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Full mask
        @(negedge clk);
        out_ready = 1'b1;
        offer(8'hA5, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b1111);
        chk("full_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("full0", 16'h1111, 2'd0, 1'b0, 8'hA5);
        chk("full0_busy", 32'(busy), 32'd1);
        chk("full0_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); chk_elem("full1", 16'h2222, 2'd1, 1'b0, 8'hA5);
        @(negedge clk); chk_elem("full2", 16'h3333, 2'd2, 1'b0, 8'hA5);
        @(negedge clk); chk_elem("full3", 16'h4444, 2'd3, 1'b1, 8'hA5);
        @(negedge clk);
        chk("full_done_valid", 32'(out_valid), 32'd0);
        chk("full_done_busy", 32'(busy), 32'd0);

        // Sparse mask 1010
        offer(8'h3C, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 4'b1010);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("sparse_a", 16'hBBBB, 2'd1, 1'b0, 8'h3C);
        chk("sparse_a_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk_elem("sparse_b", 16'hDDDD, 2'd3, 1'b1, 8'h3C);
        chk("sparse_b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("sparse_done_busy", 32'(busy), 32'd0);
        chk("sparse_done_valid", 32'(out_valid), 32'd0);

        // Zero mask in IDLE
        offer(8'h77, {16'h9999, 16'h8888, 16'h7777, 16'h6666}, 4'b0000);
        chk("zero_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("zero_valid", 32'(out_valid), 32'd0);
            chk("zero_in_ready_after", 32'(in_ready), 32'd1);
            @(negedge clk);
        end

        // Backpressure: out_ready 1,0,0,1 then random
        bp_exp[0] = 16'h0A01; bp_exp[1] = 16'h0B02; bp_exp[2] = 16'h0C03; bp_exp[3] = 16'h0D04;
        offer(8'h33, {16'h0D04, 16'h0C03, 16'h0B02, 16'h0A01}, 4'b1111);
        @(negedge clk);
        in_valid = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            case (c)
                0, 3:    out_ready = 1'b1;
                1, 2:    out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'(bp_exp[idx]));
            chk("bp_lane", 32'(out_lane), 32'(idx));
            chk("bp_last", 32'(out_last), 32'(idx == 3));
            chk("bp_in_ready", 32'(in_ready), 32'(idx == 3 && out_ready));
            if (out_ready) idx++;
            @(negedge clk);
        end
        chk("bp_all_drained", 32'(idx), 32'd4);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Back-to-back: second vector offered during first's last element
        offer(8'h11, {16'h0004, 16'h0003, 16'h0B01, 16'h0A01}, 4'b0011);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("b2b_a0", 16'h0A01, 2'd0, 1'b0, 8'h11);
        @(negedge clk);
        chk_elem("b2b_a1", 16'h0B01, 2'd1, 1'b1, 8'h11);
        offer(8'h5A, {16'h5004, 16'h5003, 16'h5002, 16'h5001}, 4'b1111);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("b2b_b0", 16'h5001, 2'd0, 1'b0, 8'h5A);
        @(negedge clk); chk_elem("b2b_b1", 16'h5002, 2'd1, 1'b0, 8'h5A);
        @(negedge clk); chk_elem("b2b_b2", 16'h5003, 2'd2, 1'b0, 8'h5A);
        @(negedge clk);
        chk_elem("b2b_b3", 16'h5004, 2'd3, 1'b1, 8'h5A);
        // Zero-mask vector during last element: discarded, go idle
        offer(8'h66, {16'h1, 16'h2, 16'h3, 16'h4}, 4'b0000);
        chk("b2b_zero_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_zero_valid", 32'(out_valid), 32'd0);
        chk("b2b_zero_busy", 32'(busy), 32'd0);

        // Mid-vector reset
        offer(8'hC3, {16'hF004, 16'hF003, 16'hF002, 16'hF001}, 4'b1111);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("mr0", 16'hF001, 2'd0, 1'b0, 8'hC3);
        @(negedge clk);
        chk_elem("mr1", 16'hF002, 2'd1, 1'b0, 8'hC3);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("mr_rst");
        chk("mr_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk_zero("mr_held");
        rst = 1'b1;
        #1;
        chk("mr_release_in_ready", 32'(in_ready), 32'd1);
        chk("mr_release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        offer(8'h99, {16'hE004, 16'hE003, 16'hE002, 16'hE001}, 4'b0101);
        @(negedge clk);
        in_valid = 1'b0;
        chk_elem("fresh0", 16'hE001, 2'd0, 1'b0, 8'h99);
        @(negedge clk);
        chk_elem("fresh1", 16'hE003, 2'd2, 1'b1, 8'h99);
        @(negedge clk);
        chk("fresh_done_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout: got no end expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
